// File: rtl/jt10_adpcm_rom_arb.sv
// Arbitrates one sample-ROM read port between ADPCM-A (strict priority) and ADPCM-B.
// Each requester keeps a one-byte last-address cache so nibble pairs cost one access.
`timescale 1ns/1ps
module jt10_adpcm_rom_arb (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic [19:0] a_addr,
   input  logic [4:0]  a_bank,
   input  logic        a_roe_n,
   output logic [7:0]  a_data,
   output logic        a_ok,
   output logic        a_late,
   input  logic [23:0] b_addr,
   input  logic        b_req,
   output logic [7:0]  b_data,
   output logic        b_ok,
   input  logic        flush,
   output logic        mem_rd,
   output logic        mem_sel,
   output logic [24:0] mem_addr,
   input  logic [7:0]  mem_data,
   input  logic        mem_ok
);
   // state  | meaning
   // IDLE   | no read in flight; issues pending A, else pending B
   // WAIT_A | A read in flight, waiting for mem_ok
   // WAIT_B | B read in flight, waiting for mem_ok
   typedef enum logic [1:0] {S_IDLE, S_WAIT_A, S_WAIT_B} state_t;

   state_t      state_q, state_d;
   logic        a_valid_q, a_valid_d, b_valid_q, b_valid_d;
   logic [24:0] a_tag_q, a_tag_d, b_tag_q, b_tag_d;
   logic [7:0]  a_byte_q, a_byte_d, b_byte_q, b_byte_d;
   logic        a_pend_q, a_pend_d, b_pend_q, b_pend_d;
   logic [24:0] a_paddr_q, a_paddr_d, b_paddr_q, b_paddr_d;
   logic        mem_rd_q, mem_rd_d, mem_sel_q, mem_sel_d;
   logic [24:0] mem_addr_q, mem_addr_d;
   logic [7:0]  a_data_q, a_data_d, b_data_q, b_data_d;
   logic        a_ok_q, a_ok_d, a_late_q, a_late_d, b_ok_q, b_ok_d;

   logic        issue_a, issue_b, done_a, done_b;
   logic        a_req, a_hit, a_miss, b_hit, b_miss;
   logic [24:0] a_req_addr, b_req_addr;

   assign a_req      = cen & ~a_roe_n;
   assign a_req_addr = {a_bank, a_addr};
   assign b_req_addr = {1'b0, b_addr};
   assign a_hit      = a_req & a_valid_q & (a_tag_q == a_req_addr) & ~flush;
   assign a_miss     = a_req & ~a_hit;
   assign b_hit      = b_req & b_valid_q & (b_tag_q == b_req_addr) & ~flush;
   assign b_miss     = b_req & ~b_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (a_pend_q)      state_d = S_WAIT_A;
            else if (b_pend_q) state_d = S_WAIT_B;
         end
         S_WAIT_A: if (mem_ok) state_d = S_IDLE;
         S_WAIT_B: if (mem_ok) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      issue_a = (state_q == S_IDLE) & a_pend_q;
      issue_b = (state_q == S_IDLE) & ~a_pend_q & b_pend_q;
      done_a  = (state_q == S_WAIT_A) & mem_rd_q & mem_ok;
      done_b  = (state_q == S_WAIT_B) & mem_rd_q & mem_ok;
   end

   always_comb begin
      a_valid_d  = a_valid_q;
      a_tag_d    = a_tag_q;
      a_byte_d   = a_byte_q;
      b_valid_d  = b_valid_q;
      b_tag_d    = b_tag_q;
      b_byte_d   = b_byte_q;
      a_pend_d   = a_pend_q;
      a_paddr_d  = a_paddr_q;
      b_pend_d   = b_pend_q;
      b_paddr_d  = b_paddr_q;
      mem_rd_d   = mem_rd_q;
      mem_sel_d  = mem_sel_q;
      mem_addr_d = mem_addr_q;
      a_data_d   = a_data_q;
      b_data_d   = b_data_q;
      a_ok_d     = a_hit | done_a;
      b_ok_d     = b_hit | done_b;
      // a miss while A is queued or in flight means memory is too slow for the slot rate
      a_late_d   = a_miss & (a_pend_q | (state_q == S_WAIT_A));

      if (done_a) begin
         a_data_d = mem_data;
         mem_rd_d = 1'b0;
         a_valid_d = 1'b1;
         a_tag_d   = mem_addr_q;
         a_byte_d  = mem_data;
      end
      if (done_b) begin
         b_data_d = mem_data;
         mem_rd_d = 1'b0;
         b_valid_d = 1'b1;
         b_tag_d   = mem_addr_q;
         b_byte_d  = mem_data;
      end
      if (flush) begin
         a_valid_d = 1'b0;
         b_valid_d = 1'b0;
      end
      // a hit reflects the most recent request, so it wins over a same-edge fill
      if (a_hit) a_data_d = a_byte_q;
      if (b_hit) b_data_d = b_byte_q;

      if (issue_a) begin
         a_pend_d   = 1'b0;
         mem_rd_d   = 1'b1;
         mem_sel_d  = 1'b0;
         mem_addr_d = a_paddr_q;
      end
      if (issue_b) begin
         b_pend_d   = 1'b0;
         mem_rd_d   = 1'b1;
         mem_sel_d  = 1'b1;
         mem_addr_d = b_paddr_q;
      end
      if (a_miss) begin
         a_pend_d  = 1'b1;
         a_paddr_d = a_req_addr;
      end
      if (b_miss) begin
         b_pend_d  = 1'b1;
         b_paddr_d = b_req_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_q  <= 1'b0;
         a_tag_q    <= '0;
         a_byte_q   <= '0;
         b_valid_q  <= 1'b0;
         b_tag_q    <= '0;
         b_byte_q   <= '0;
         a_pend_q   <= 1'b0;
         a_paddr_q  <= '0;
         b_pend_q   <= 1'b0;
         b_paddr_q  <= '0;
         mem_rd_q   <= 1'b0;
         mem_sel_q  <= 1'b0;
         mem_addr_q <= '0;
         a_data_q   <= '0;
         b_data_q   <= '0;
         a_ok_q     <= 1'b0;
         a_late_q   <= 1'b0;
         b_ok_q     <= 1'b0;
      end else begin
         a_valid_q  <= a_valid_d;
         a_tag_q    <= a_tag_d;
         a_byte_q   <= a_byte_d;
         b_valid_q  <= b_valid_d;
         b_tag_q    <= b_tag_d;
         b_byte_q   <= b_byte_d;
         a_pend_q   <= a_pend_d;
         a_paddr_q  <= a_paddr_d;
         b_pend_q   <= b_pend_d;
         b_paddr_q  <= b_paddr_d;
         mem_rd_q   <= mem_rd_d;
         mem_sel_q  <= mem_sel_d;
         mem_addr_q <= mem_addr_d;
         a_data_q   <= a_data_d;
         b_data_q   <= b_data_d;
         a_ok_q     <= a_ok_d;
         a_late_q   <= a_late_d;
         b_ok_q     <= b_ok_d;
      end
   end

   assign mem_rd   = mem_rd_q;
   assign mem_sel  = mem_sel_q;
   assign mem_addr = mem_addr_q;
   assign a_data   = a_data_q;
   assign a_ok     = a_ok_q;
   assign a_late   = a_late_q;
   assign b_data   = b_data_q;
   assign b_ok     = b_ok_q;

endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// Directed bench for jt10_adpcm_rom_arb: hit/miss, priority, overrun, flush and reset.
`timescale 1ns/1ps
module tb_jt10_adpcm_rom_arb;
   logic        clk = 1'b0;
   logic        rst_n, cen, a_roe_n, b_req, flush, mem_ok;
   logic [19:0] a_addr;
   logic [4:0]  a_bank;
   logic [23:0] b_addr;
   logic [7:0]  mem_data, a_data, b_data;
   logic        a_ok, a_late, b_ok, mem_rd, mem_sel;
   logic [24:0] mem_addr;
   int          n_tests = 0;
   int          n_fail  = 0;

   jt10_adpcm_rom_arb dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .a_addr(a_addr), .a_bank(a_bank),
      .a_roe_n(a_roe_n), .a_data(a_data), .a_ok(a_ok), .a_late(a_late),
      .b_addr(b_addr), .b_req(b_req), .b_data(b_data), .b_ok(b_ok),
      .flush(flush), .mem_rd(mem_rd), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_ok(mem_ok)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic [24:0] ad);
      a_bank  = ad[24:20];
      a_addr  = ad[19:0];
      cen     = 1'b1;
      a_roe_n = 1'b0;
   endtask

   task automatic clr_reqs();
      cen     = 1'b0;
      a_roe_n = 1'b1;
      b_req   = 1'b0;
   endtask

   task automatic req_a(input logic [24:0] ad);
      set_a(ad);
      tick();
      clr_reqs();
   endtask

   task automatic req_b(input logic [23:0] ad);
      b_addr = ad;
      b_req  = 1'b1;
      tick();
      clr_reqs();
   endtask

   task automatic complete(input logic [7:0] d);
      mem_ok   = 1'b1;
      mem_data = d;
      tick();
      mem_ok   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cen = 1'b0; a_roe_n = 1'b1; b_req = 1'b0; flush = 1'b0;
      mem_ok = 1'b0; a_addr = '0; a_bank = '0; b_addr = '0; mem_data = '0;
      tick(); tick();
      check("rst mem_rd",   {31'd0, mem_rd},   0);
      check("rst mem_sel",  {31'd0, mem_sel},  0);
      check("rst mem_addr", {7'd0, mem_addr},  0);
      check("rst a_data",   {24'd0, a_data},   0);
      check("rst b_data",   {24'd0, b_data},   0);
      check("rst a_ok",     {31'd0, a_ok},     0);
      check("rst b_ok",     {31'd0, b_ok},     0);
      check("rst a_late",   {31'd0, a_late},   0);
      rst_n = 1'b1;
      tick();

      // A miss, issue one clk after capture, completion with 0x5A
      req_a(25'h0012345);
      check("a1 capture rd", {31'd0, mem_rd}, 0);
      check("a1 capture ok", {31'd0, a_ok}, 0);
      tick();
      check("a1 mem_rd",   {31'd0, mem_rd}, 1);
      check("a1 mem_sel",  {31'd0, mem_sel}, 0);
      check("a1 mem_addr", {7'd0, mem_addr}, 32'h0012345);
      tick(); tick();
      check("a1 hold addr", {7'd0, mem_addr}, 32'h0012345);
      complete(8'h5A);
      check("a1 a_ok",   {31'd0, a_ok}, 1);
      check("a1 a_data", {24'd0, a_data}, 32'h5A);
      check("a1 rd drop", {31'd0, mem_rd}, 0);
      tick();
      check("a1 a_ok pulse", {31'd0, a_ok}, 0);

      // Hit on same address: a_ok next clk, no memory access
      req_a(25'h0012345);
      check("a2 hit ok",   {31'd0, a_ok}, 1);
      check("a2 hit data", {24'd0, a_data}, 32'h5A);
      tick();
      check("a2 hit ok end", {31'd0, a_ok}, 0);
      check("a2 no rd", {31'd0, mem_rd}, 0);
      tick();
      check("a2 still no rd", {31'd0, mem_rd}, 0);

      // Flush with the same request forces a miss
      flush = 1'b1;
      req_a(25'h0012345);
      flush = 1'b0;
      check("fl no hit", {31'd0, a_ok}, 0);
      tick();
      check("fl mem_rd", {31'd0, mem_rd}, 1);
      check("fl addr",   {7'd0, mem_addr}, 32'h0012345);
      complete(8'h77);
      check("fl a_data", {24'd0, a_data}, 32'h77);
      tick();

      // Simultaneous A and B misses: A first, then B
      set_a(25'h0100000);
      b_addr = 24'h000200;
      b_req  = 1'b1;
      tick();
      clr_reqs();
      tick();
      check("pr a rd",   {31'd0, mem_rd}, 1);
      check("pr a sel",  {31'd0, mem_sel}, 0);
      check("pr a addr", {7'd0, mem_addr}, 32'h0100000);
      complete(8'h11);
      check("pr a ok",   {31'd0, a_ok}, 1);
      check("pr a data", {24'd0, a_data}, 32'h11);
      check("pr b not ok", {31'd0, b_ok}, 0);
      check("pr gap rd", {31'd0, mem_rd}, 0);
      tick();
      check("pr b rd",   {31'd0, mem_rd}, 1);
      check("pr b sel",  {31'd0, mem_sel}, 1);
      check("pr b addr", {7'd0, mem_addr}, 32'h0000200);
      complete(8'h22);
      check("pr b ok",   {31'd0, b_ok}, 1);
      check("pr b data", {24'd0, b_data}, 32'h22);
      tick();

      // B in flight, A arrives and waits
      req_b(24'h000300);
      tick();
      check("bf b sel", {31'd0, mem_sel}, 1);
      req_a(25'h0000040);
      check("bf no late", {31'd0, a_late}, 0);
      check("bf sel kept", {31'd0, mem_sel}, 1);
      tick();
      complete(8'h33);
      check("bf b ok",   {31'd0, b_ok}, 1);
      check("bf b data", {24'd0, b_data}, 32'h33);
      check("bf rd drop", {31'd0, mem_rd}, 0);
      tick();
      check("bf a rd",   {31'd0, mem_rd}, 1);
      check("bf a sel",  {31'd0, mem_sel}, 0);
      check("bf a addr", {7'd0, mem_addr}, 32'h0000040);
      complete(8'h44);
      check("bf a data", {24'd0, a_data}, 32'h44);
      tick();

      // A overrun: second miss while the first is in flight
      req_a(25'h0000010);
      tick();
      check("ov addr1", {7'd0, mem_addr}, 32'h0000010);
      req_a(25'h0000020);
      check("ov late", {31'd0, a_late}, 1);
      tick();
      check("ov late pulse", {31'd0, a_late}, 0);
      complete(8'h55);
      check("ov ok1",   {31'd0, a_ok}, 1);
      check("ov data1", {24'd0, a_data}, 32'h55);
      tick();
      check("ov rd2",   {31'd0, mem_rd}, 1);
      check("ov addr2", {7'd0, mem_addr}, 32'h0000020);
      complete(8'h66);
      check("ov ok2",   {31'd0, a_ok}, 1);
      check("ov data2", {24'd0, a_data}, 32'h66);
      tick();
      req_a(25'h0000020);
      check("ov hit ok",   {31'd0, a_ok}, 1);
      check("ov hit data", {24'd0, a_data}, 32'h66);
      tick();

      // B hit on 0x300 before reset
      req_b(24'h000300);
      check("bh ok",   {31'd0, b_ok}, 1);
      check("bh data", {24'd0, b_data}, 32'h33);
      tick();

      // Reset during WAIT_B abandons the read and clears the cache
      req_b(24'h000400);
      tick();
      check("rs rd before", {31'd0, mem_rd}, 1);
      rst_n = 1'b0;
      #1;
      check("rs rd async", {31'd0, mem_rd}, 0);
      tick(); tick();
      check("rs b_ok", {31'd0, b_ok}, 0);
      rst_n = 1'b1;
      tick();
      req_b(24'h000300);
      check("rs miss no ok", {31'd0, b_ok}, 0);
      tick();
      check("rs b rd",   {31'd0, mem_rd}, 1);
      check("rs b sel",  {31'd0, mem_sel}, 1);
      check("rs b addr", {7'd0, mem_addr}, 32'h0000300);
      complete(8'h99);
      check("rs b ok",   {31'd0, b_ok}, 1);
      check("rs b data", {24'd0, b_data}, 32'h99);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
